// File: rtl/scanline_mode_ctrl.sv
// Scanline mode sequencer: validates host/preset requests, applies them to scnl_sw on a vsync edge.
// Latency: the new mode appears on the clock edge that samples the vsync edge (or the watchdog expiry).
// Backpressure: cfg_ready is low while a change is pending; requests then are dropped. Watchdog: SCANLINE_MODE_CTRL_TIMEOUT_EN.
module scanline_mode_ctrl #(
   parameter logic [3:0] DEFAULT_MODE   = 4'd0,
   parameter bit         VS_ACTIVE_HIGH = 1'b1,
   parameter int         TIMEOUT_CYCLES = 2000000
) (
   input  logic       clk_vid,
   input  logic       reset_n,
   input  logic       cfg_valid,
   input  logic [3:0] cfg_mode,
   output logic       cfg_ready,
   input  logic       cycle_req,
   input  logic       core_vs,
   output logic [3:0] scnl_sw,
   output logic       busy,
   output logic       applied,
   output logic       cfg_err,
   output logic [3:0] preset_idx
);

   typedef enum logic {IDLE, PENDING} state_t;

   localparam logic VS_LVL = VS_ACTIVE_HIGH;

   function automatic logic [3:0] idx_to_mode(input logic [3:0] i);
      case (i)
         4'd0: return 4'd0;
         4'd1: return 4'd1;
         4'd2: return 4'd2;
         4'd3: return 4'd3;
         4'd4: return 4'd4;
         4'd5: return 4'd8;
         4'd6: return 4'd12;
         4'd7: return 4'd5;
         4'd8: return 4'd10;
         4'd9: return 4'd15;
         default: return 4'd0;
      endcase
   endfunction

   function automatic logic mode_legal(input logic [3:0] m);
      case (m)
         4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd8, 4'd12, 4'd5, 4'd10, 4'd15: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] mode_index(input logic [3:0] m);
      case (m)
         4'd0:  return 4'd0;
         4'd1:  return 4'd1;
         4'd2:  return 4'd2;
         4'd3:  return 4'd3;
         4'd4:  return 4'd4;
         4'd8:  return 4'd5;
         4'd12: return 4'd6;
         4'd5:  return 4'd7;
         4'd10: return 4'd8;
         4'd15: return 4'd9;
         default: return 4'd0;
      endcase
   endfunction

   state_t     state, next_state;
   logic       vs_q;
   logic       vs_edge;
   logic       timeout_hit;
   logic       apply;
   logic       err_d;
   logic [3:0] pending, pending_d;
   logic [3:0] next_idx;

   assign vs_edge  = (core_vs == VS_LVL) && (vs_q != VS_LVL);
   assign next_idx = (preset_idx == 4'd9) ? 4'd0 : preset_idx + 4'd1;

`ifdef SCANLINE_MODE_CTRL_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

   logic [WD_W-1:0] wdog;

   // Held at zero in IDLE so every PENDING stay starts counting from zero.
   always_ff @(posedge clk_vid or negedge reset_n) begin
      if (!reset_n)
         wdog <= '0;
      else if (state == IDLE)
         wdog <= '0;
      else
         wdog <= wdog + 1'b1;
   end

   assign timeout_hit = (state == PENDING) && (wdog == WD_LAST);
`else
   // Without the watchdog PENDING waits for vsync forever; the limit can never be reached.
   assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

   always_comb begin
      next_state = state;
      pending_d  = pending;
      cfg_ready  = 1'b0;
      busy       = 1'b0;
      apply      = 1'b0;
      err_d      = 1'b0;
      case (state)
         IDLE: begin
            cfg_ready = 1'b1;
            // A host request always wins over a simultaneous preset step, legal or not.
            if (cfg_valid) begin
               if (mode_legal(cfg_mode)) begin
                  pending_d  = cfg_mode;
                  next_state = PENDING;
               end else begin
                  err_d = 1'b1;
               end
            end else if (cycle_req) begin
               pending_d  = idx_to_mode(next_idx);
               next_state = PENDING;
            end
         end
         PENDING: begin
            busy = 1'b1;
            if (vs_edge || timeout_hit) begin
               apply      = 1'b1;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk_vid or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         vs_q       <= VS_LVL;
         pending    <= '0;
         scnl_sw    <= DEFAULT_MODE;
         preset_idx <= mode_index(DEFAULT_MODE);
         applied    <= 1'b0;
         cfg_err    <= 1'b0;
      end else begin
         state   <= next_state;
         vs_q    <= core_vs;
         pending <= pending_d;
         applied <= apply;
         cfg_err <= err_d;
         if (apply) begin
            scnl_sw    <= pending;
            preset_idx <= mode_index(pending);
         end
      end
   end

endmodule

// File: tb/tb_scanline_mode_ctrl.sv
// Scoreboard bench for scanline_mode_ctrl: stimulus queues expected applied/cfg_err events, a monitor pops and compares.
module tb_scanline_mode_ctrl;

   logic       clk_vid = 1'b0;
   logic       reset_n;
   logic       cfg_valid;
   logic [3:0] cfg_mode;
   logic       cfg_ready;
   logic       cycle_req;
   logic       core_vs;
   logic [3:0] scnl_sw;
   logic       busy;
   logic       applied;
   logic       cfg_err;
   logic [3:0] preset_idx;

   int total = 0;
   int bad   = 0;

   typedef struct {
      bit         is_err;
      logic [3:0] sw;
      logic [3:0] idx;
   } exp_t;

   exp_t exp_q[$];

   scanline_mode_ctrl #(
      .DEFAULT_MODE  (4'd0),
      .VS_ACTIVE_HIGH(1'b1),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .clk_vid   (clk_vid),
      .reset_n   (reset_n),
      .cfg_valid (cfg_valid),
      .cfg_mode  (cfg_mode),
      .cfg_ready (cfg_ready),
      .cycle_req (cycle_req),
      .core_vs   (core_vs),
      .scnl_sw   (scnl_sw),
      .busy      (busy),
      .applied   (applied),
      .cfg_err   (cfg_err),
      .preset_idx(preset_idx)
   );

   always #5 clk_vid = ~clk_vid;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, want);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk_vid);
      #1;
   endtask

   task automatic push_app(input logic [3:0] sw, input logic [3:0] idx);
      exp_t e;
      e.is_err = 1'b0; e.sw = sw; e.idx = idx;
      exp_q.push_back(e);
   endtask

   task automatic push_err(input logic [3:0] sw, input logic [3:0] idx);
      exp_t e;
      e.is_err = 1'b1; e.sw = sw; e.idx = idx;
      exp_q.push_back(e);
   endtask

   task automatic send_cfg(input logic [3:0] m);
      cfg_valid = 1'b1;
      cfg_mode  = m;
      chk("cfg_ready_before_send", cfg_ready, 1);
      cyc(1);
      cfg_valid = 1'b0;
   endtask

   task automatic pulse_cycle();
      cycle_req = 1'b1;
      cyc(1);
      cycle_req = 1'b0;
   endtask

   task automatic vsync();
      core_vs = 1'b1;
      cyc(1);
      core_vs = 1'b0;
   endtask

   // Monitor: every applied / cfg_err pulse must match the oldest queued expectation.
   always @(negedge clk_vid) begin
      if (reset_n && (applied || cfg_err)) begin
         total++;
         if (applied && cfg_err) begin
            bad++;
            $display("FAIL both_pulses: applied=%0b cfg_err=%0b", applied, cfg_err);
         end else if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event: applied=%0b cfg_err=%0b scnl_sw=%0d", applied, cfg_err, scnl_sw);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (cfg_err !== e.is_err || scnl_sw !== e.sw || preset_idx !== e.idx) begin
               bad++;
               $display("FAIL event: got err=%0b sw=%0d idx=%0d expected err=%0b sw=%0d idx=%0d",
                        cfg_err, scnl_sw, preset_idx, e.is_err, e.sw, e.idx);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL sim_timeout: got running expected finished");
      $fatal(1, "bench time limit");
   end

   initial begin
      reset_n   = 1'b0;
      cfg_valid = 1'b0;
      cfg_mode  = 4'd0;
      cycle_req = 1'b0;
      core_vs   = 1'b0;
      #12;
      chk("rst_scnl_sw", scnl_sw, 0);
      chk("rst_preset_idx", preset_idx, 0);
      chk("rst_cfg_ready", cfg_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_applied", applied, 0);
      chk("rst_cfg_err", cfg_err, 0);
      reset_n = 1'b1;
      cyc(2);
      chk("no_false_edge_after_reset", applied, 0);

      // Host request for mode 10 waits for vsync.
      send_cfg(4'd10);
      push_app(4'd10, 4'd8);
      chk("t1_busy", busy, 1);
      chk("t1_ready_low", cfg_ready, 0);
      cyc(3);
      chk("t1_hold_sw", scnl_sw, 0);
      vsync();
      chk("t1_sw", scnl_sw, 10);
      chk("t1_idx", preset_idx, 8);
      chk("t1_applied", applied, 1);
      chk("t1_ready_back", cfg_ready, 1);
      cyc(1);
      chk("t1_applied_one_cycle", applied, 0);

      // Illegal code 6 is rejected.
      send_cfg(4'd6);
      push_err(4'd10, 4'd8);
      chk("t2_err", cfg_err, 1);
      chk("t2_busy", busy, 0);
      cyc(1);
      chk("t2_err_one_cycle", cfg_err, 0);
      chk("t2_sw", scnl_sw, 10);

      // Preset wrap 9 -> 0 -> 1.
      send_cfg(4'd15);
      push_app(4'd15, 4'd9);
      vsync();
      cyc(1);
      pulse_cycle();
      push_app(4'd0, 4'd0);
      vsync();
      chk("t3_wrap_sw", scnl_sw, 0);
      chk("t3_wrap_idx", preset_idx, 0);
      cyc(1);
      pulse_cycle();
      push_app(4'd1, 4'd1);
      vsync();
      chk("t3_next_sw", scnl_sw, 1);

      // cfg beats cycle_req; requests during PENDING ignored.
      cyc(1);
      send_cfg(4'd0);
      push_app(4'd0, 4'd0);
      vsync();
      cyc(1);
      cfg_valid = 1'b1; cfg_mode = 4'd3; cycle_req = 1'b1;
      cyc(1);
      cfg_valid = 1'b0; cycle_req = 1'b0;
      push_app(4'd3, 4'd3);
      cycle_req = 1'b1; cfg_valid = 1'b1; cfg_mode = 4'd8;
      cyc(1);
      cycle_req = 1'b0; cfg_valid = 1'b0;
      chk("t4_busy", busy, 1);
      vsync();
      chk("t4_sw", scnl_sw, 3);
      chk("t4_idx", preset_idx, 3);

      // Request accepted on a vsync edge waits for the next edge.
      cyc(1);
      cfg_valid = 1'b1; cfg_mode = 4'd4; core_vs = 1'b1;
      cyc(1);
      cfg_valid = 1'b0;
      push_app(4'd4, 4'd4);
      chk("t5_busy", busy, 1);
      chk("t5_sw_hold", scnl_sw, 3);
      cyc(1);
      core_vs = 1'b0;
      cyc(1);
      chk("t5_sw_hold2", scnl_sw, 3);
      vsync();
      chk("t5_sw", scnl_sw, 4);

      // Reset mid-PENDING discards the request.
      cyc(1);
      send_cfg(4'd12);
      cyc(2);
      #2 reset_n = 1'b0;
      #1;
      chk("t6_rst_sw", scnl_sw, 0);
      chk("t6_rst_idx", preset_idx, 0);
      chk("t6_rst_busy", busy, 0);
      chk("t6_rst_ready", cfg_ready, 1);
      #2 reset_n = 1'b1;
      cyc(2);
      vsync();
      chk("t6_no_applied", applied, 0);
      chk("t6_sw_default", scnl_sw, 0);

      // Watchdog with core_vs held low.
      cyc(2);
      send_cfg(4'd2);
`ifdef SCANLINE_MODE_CTRL_TIMEOUT_EN
      push_app(4'd2, 4'd2);
      cyc(15);
      chk("t7_before_timeout", scnl_sw, 0);
      cyc(1);
      chk("t7_timeout_sw", scnl_sw, 2);
      chk("t7_timeout_applied", applied, 1);
`else
      cyc(1000);
      chk("t7_no_timeout_sw", scnl_sw, 0);
      chk("t7_still_busy", busy, 1);
      push_app(4'd2, 4'd2);
      vsync();
      chk("t7_vsync_sw", scnl_sw, 2);
`endif

      cyc(4);
      chk("queue_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
